wide_add_seq: RTL and testbench



---
 rtl/wide_add_seq_pkg.sv | 10 +
 rtl/cla_32bit.sv | 33 +++
 rtl/wide_add_seq.sv | 108 ++++++++++
 tb/tb_wide_add_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the sequential wide adder: word width and FSM state encoding.
package wide_add_seq_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } was_state_t;
endpackage

// File: rtl/cla_32bit.sv
// 32-bit adder built from 4-bit carry-lookahead groups; group carries ripple between groups.
module cla_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : grp
      localparam int L = 4 * gi;
      // Every carry inside the group is expanded directly from the group carry-in.
      assign c[L+1] = g[L] | (p[L] & c[L]);
      assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & c[L]);
      assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                    | (p[L+2] & p[L+1] & p[L] & c[L]);
      assign c[L+4] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                    | (p[L+3] & p[L+2] & p[L+1] & g[L])
                    | (p[L+3] & p[L+2] & p[L+1] & p[L] & c[L]);
    end
  endgenerate

  assign sum  = p ^ c[31:0];
  assign cout = c[32];
endmodule

// File: rtl/wide_add_seq.sv
// Multi-word add/subtract: one 32-bit word per cycle through a single cla_32bit, carry held in a register.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] A,
  input  logic [WORD_W*NWORDS-1:0] B,
  input  logic                     Cin,
  input  logic                     SUB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] S,
  output logic                     Cout
);
  localparam int W     = WORD_W * NWORDS;
  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  was_state_t       state_reg;
  was_state_t       state_next;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     s_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             out_valid_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      word_lo;
  logic             last_word;
  logic [WORD_W-1:0] sum_w;
  logic             cout_w;

  assign word_lo   = WORD_W * {{(32-IDX_W){1'b0}}, idx_reg};
  assign last_word = (idx_reg == LAST_IDX);

  cla_32bit u_cla (
    .a    (a_reg[word_lo +: WORD_W]),
    .b    (b_reg[word_lo +: WORD_W]),
    .cin  (carry_reg),
    .sum  (sum_w),
    .cout (cout_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_word) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE);
  end

  // Subtraction is A + ~B + 1: B is inverted at accept and the carry seeded with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      s_reg         <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      idx_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= A;
            b_reg     <= SUB ? ~B : B;
            carry_reg <= SUB ? 1'b1 : Cin;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          s_reg[word_lo +: WORD_W] <= sum_w;
          carry_reg                <= cout_w;
          idx_reg                  <= idx_reg + IDX_W'(1);
          if (last_word) begin
            cout_reg      <= cout_w;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign S         = s_reg;
  assign Cout      = cout_reg;
  assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (NWORDS=4): directed cases plus random ops against an arithmetic model.
module tb_wide_add_seq;
  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         SUB = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] S;
  logic         Cout;

  int n_cmp = 0;
  int n_bad = 0;

  wide_add_seq #(.NWORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Transaction-level model: an op is accepted when idle, visible NW+1 edges later, freed on release.
  bit         m_busy = 0;
  bit         m_release = 0;
  int         m_edges = 0;
  logic [W:0] m_res = '0;
  always @(negedge clk) begin
    bit exp_ov;
    if (rst) begin
      m_busy    = 0;
      m_release = 0;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_S", S, '0);
      chk("rst_Cout", W'(Cout), W'(0));
    end else begin
      if (m_release) begin
        m_busy    = 0;
        m_release = 0;
      end
      if (m_busy) m_edges++;
      exp_ov = m_busy && (m_edges >= NW + 1);
      chk("mon_in_ready", W'(in_ready), W'(!m_busy));
      chk("mon_out_valid", W'(out_valid), W'(exp_ov));
      if (exp_ov) begin
        chk("mon_S", S, m_res[W-1:0]);
        chk("mon_Cout", W'(Cout), W'(m_res[W]));
      end
      if (!m_busy && in_valid) begin
        m_res   = model(A, B, Cin, SUB);
        m_busy  = 1;
        m_edges = 0;
      end else if (exp_ov && out_ready) begin
        m_release = 1;
      end
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                    input logic sub, input int hold, input bit pulse,
                    output logic [W-1:0] s, output logic c, output int lat);
    int n;
    logic [W-1:0] s_hold;
    logic         c_hold;
    s = '0; c = 1'b0; lat = 0;
    @(posedge clk); #1;
    A = a; B = b; Cin = cin; SUB = sub; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", W'(n), W'(0));
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = rnd_w(); B = rnd_w(); Cin = ~cin; SUB = ~sub;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    if (!out_valid) chk("result_timeout", W'(lat), W'(NW + 1));
    s = S; c = Cout;
    s_hold = S; c_hold = Cout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (pulse) begin
        in_valid = 1'b1;
        A = rnd_w(); B = rnd_w(); Cin = $urandom_range(0, 1); SUB = $urandom_range(0, 1);
      end
      @(negedge clk);
      chk("hold_in_ready", W'(in_ready), W'(0));
      chk("hold_S", S, s_hold);
      chk("hold_Cout", W'(Cout), W'(c_hold));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("release_in_ready", W'(in_ready), W'(1));
    chk("release_out_valid", W'(out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] s, a, b;
    logic         c, ci, sb;
    logic [W:0]   e;
    int           lat;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    op(W'(3), W'(5), 1'b0, 1'b0, 0, 0, s, c, lat);
    $display("op add 3+5: S=%h Cout=%0d lat=%0d", s, c, lat);
    chk("add_small_S", s, W'(8));
    chk("add_small_Cout", W'(c), W'(0));
    chk("add_small_latency", W'(lat), W'(5));

    op({W{1'b1}}, W'(1), 1'b0, 1'b0, 0, 0, s, c, lat);
    $display("op add ones+1: S=%h Cout=%0d", s, c);
    chk("ripple_all_S", s, '0);
    chk("ripple_all_Cout", W'(c), W'(1));

    op(W'(64'hFFFF_FFFF), W'(1), 1'b0, 1'b0, 0, 0, s, c, lat);
    $display("op add word0 carry: S=%h Cout=%0d", s, c);
    chk("ripple_w0_S", s, W'(64'h1_0000_0000));
    chk("ripple_w0_Cout", W'(c), W'(0));

    op(W'(5), W'(3), 1'b0, 1'b1, 0, 0, s, c, lat);
    $display("op sub 5-3: S=%h Cout=%0d", s, c);
    chk("sub_pos_S", s, W'(2));
    chk("sub_pos_Cout", W'(c), W'(1));

    op(W'(3), W'(5), 1'b1, 1'b1, 0, 0, s, c, lat);
    $display("op sub 3-5: S=%h Cout=%0d", s, c);
    chk("sub_neg_S", s, {{(W-1){1'b1}}, 1'b0});
    chk("sub_neg_Cout", W'(c), W'(0));

    op(W'(32'h1111_0000), W'(32'h0000_2222), 1'b1, 1'b0, 6, 1, s, c, lat);
    $display("op add backpressure: S=%h Cout=%0d", s, c);
    chk("bp_S", s, W'(32'h1111_2223));
    chk("bp_Cout", W'(c), W'(0));

    // Reset two cycles into RUN must abort the operation with no output.
    @(posedge clk); #1;
    A = rnd_w(); B = rnd_w(); Cin = 1'b0; SUB = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    $display("op reset mid-run: out_valid=%0d in_ready=%0d S=%h", out_valid, in_ready, S);
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_S", S, '0);
    @(posedge clk); #1 rst = 1'b0;

    op(W'(32'h0000_ABCD), W'(32'h0000_1234), 1'b1, 1'b0, 0, 0, s, c, lat);
    $display("op add after reset: S=%h Cout=%0d", s, c);
    chk("post_rst_S", s, W'(32'h0000_BE02));
    chk("post_rst_Cout", W'(c), W'(0));

    for (int i = 0; i < 30; i++) begin
      a  = rnd_w();
      b  = (i % 5 == 0) ? ~a : rnd_w();
      ci = $urandom_range(0, 1);
      sb = $urandom_range(0, 1);
      op(a, b, ci, sb, $urandom_range(0, 3), $urandom_range(0, 1), s, c, lat);
      e = model(a, b, ci, sb);
      $display("op rnd %0d sub=%0d cin=%0d: S=%h Cout=%0d", i, sb, ci, s, c);
      chk("rnd_S", s, e[W-1:0]);
      chk("rnd_Cout", W'(c), W'(e[W]));
      chk("rnd_latency", W'(lat), W'(NW + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
